fetch_queue_stage: RTL and testbench

//   Parametrised instruction-fetch stage with a prefetch queue between PC/IMEM and the IF/ID boundary.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue_stage_if.sv | 26 ++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_queue_stage.sv | 107 ++++++++++
 tb/tb_fetch_queue_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching instruction-fetch stage.
// Provides the queue entry layout and the bubble instruction encoding.
package fetch_pkg;

    localparam int FQ_XLEN = 32;

    // addi x0,x0,0
    localparam logic [FQ_XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bus: EX redirect, hazard controls, IMEM port and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_queue_stage_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pctargetE;
    logic            pcsrcE;
    logic            stallD;
    logic            flushD;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instD;
    logic [XLEN-1:0] pcD;
    logic [XLEN-1:0] pcplus4D;
    logic            validD;

    modport master (
        input  pctargetE, pcsrcE, stallD, flushD, imem_rdata,
        output imem_addr, instD, pcD, pcplus4D, validD
    );

    modport slave (
        output pctargetE, pcsrcE, stallD, flushD, imem_rdata,
        input  imem_addr, instD, pcD, pcplus4D, validD
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of QDEPTH {pc, inst} entries (QDEPTH power of 2).
// Ports: clk, rst, clear_i, push_i, pop_i, wdata_i -> head_o, full_o, empty_o.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clear_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  fq_entry_t wdata_i,
    output fq_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    fq_entry_t       mem_q [QDEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CW'(QDEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch with prefetch queue feeding the IF/ID register.
// Ports: clk, rst (sync, active-high), bus (fetch_queue_stage_if.master);
// with FETCH_PERF_CNT_EN defined also perf_stall_cnt, perf_redirect_cnt.
module fetch_queue_stage #(
    parameter int                  XLEN     = fetch_pkg::FQ_XLEN,
    parameter int                  QDEPTH   = 4,
    parameter logic [XLEN-1:0]     RESET_PC = '0,
    parameter logic [XLEN-1:0]     NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_queue_stage_if.master    bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_redirect_cnt
`endif
);
    import fetch_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, pcd_q, pc4_q;
    logic            valid_q;
    fq_entry_t       wentry, head;
    logic            full, empty, push, pop;
    logic            unused_tgt;

    // Redirect targets are word aligned; low bits are dropped.
    assign unused_tgt = ^bus.pctargetE[1:0];

    assign bus.imem_addr = pc_q;
    assign bus.instD     = inst_q;
    assign bus.pcD       = pcd_q;
    assign bus.pcplus4D  = pc4_q;
    assign bus.validD    = valid_q;

    // Full is judged on the registered count, so a same-cycle pop
    // does not free a slot for the push.
    assign push = !full && !bus.pcsrcE;
    assign pop  = !bus.stallD && !bus.flushD && !bus.pcsrcE && !empty;

    assign wentry.pc   = pc_q;
    assign wentry.inst = bus.imem_rdata;

    fetch_fifo #(
        .QDEPTH  (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.pcsrcE),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        pc_d = pc_q;
        if (bus.pcsrcE)  pc_d = {bus.pctargetE[XLEN-1:2], 2'b00};
        else if (push)   pc_d = pc_q + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    // Bubbles keep pcD/pcplus4D; a stall without flush/redirect holds all.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q  <= NOP_INST;
            pcd_q   <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.pcsrcE || bus.flushD ||
                     (!bus.stallD && empty)) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (pop) begin
            inst_q  <= head.inst;
            pcd_q   <= head.pc;
            pc4_q   <= head.pc + XLEN'(4);
            valid_q <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, redir_cnt_q;

    assign perf_stall_cnt    = stall_cnt_q;
    assign perf_redirect_cnt = redir_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (bus.stallD && !bus.pcsrcE && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.pcsrcE && redir_cnt_q != '1)
                redir_cnt_q <= redir_cnt_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: queue-level reference model,
// directed scenarios followed by randomized controls.
module tb_fetch_queue_stage;

    localparam int QD = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_queue_stage_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_redirect_cnt;
`endif

    fetch_queue_stage #(
        .XLEN     (32),
        .QDEPTH   (QD),
        .RESET_PC (32'h0),
        .NOP_INST (NOP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    // Memory word i holds i+1.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        v;
        logic [31:0] addr;
        logic [31:0] sc;
        logic [31:0] rc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: list of fetched PCs not yet handed to decode.
    logic [31:0] m_q[$];
    logic [31:0] m_pc, m_inst, m_pcd, m_pc4, m_sc, m_rc;
    logic        m_v;

    task automatic step(input logic r, input logic ps,
                        input logic [31:0] tg,
                        input logic st, input logic fl);
        exp_t e;
        bit was_full;
        logic [31:0] h;
        if (r) begin
            m_q.delete();
            m_pc = 0; m_inst = NOP; m_pcd = 0; m_pc4 = 0; m_v = 0;
            m_sc = 0; m_rc = 0;
        end else begin
            if (st && !ps && m_sc != 32'hFFFF_FFFF) m_sc++;
            if (ps && m_rc != 32'hFFFF_FFFF) m_rc++;
            if (ps) begin
                m_q.delete();
                m_pc = tg & ~32'd3;
                m_inst = NOP; m_v = 0;
            end else begin
                was_full = (m_q.size() == QD);
                if (fl) begin
                    m_inst = NOP; m_v = 0;
                end else if (!st) begin
                    if (m_q.size() > 0) begin
                        h = m_q.pop_front();
                        m_inst = mem_word(h); m_pcd = h;
                        m_pc4 = h + 4; m_v = 1;
                    end else begin
                        m_inst = NOP; m_v = 0;
                    end
                end
                if (!was_full) begin
                    m_q.push_back(m_pc);
                    m_pc = m_pc + 4;
                end
            end
        end
        e.inst = m_inst; e.pc = m_pcd; e.pc4 = m_pc4; e.v = m_v;
        e.addr = m_pc; e.sc = m_sc; e.rc = m_rc;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic ps,
                       input logic [31:0] tg,
                       input logic st, input logic fl);
        @(negedge clk);
        rst = r;
        bus.pcsrcE = ps; bus.pctargetE = tg;
        bus.stallD = st; bus.flushD = fl;
        step(r, ps, tg, st, fl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    // Monitor: the IF/ID register updates every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.instD !== e.inst || bus.pcD !== e.pc ||
                bus.pcplus4D !== e.pc4 || bus.validD !== e.v ||
                bus.imem_addr !== e.addr) begin
                n_err++;
                $display("FAIL dreg t=%0t got inst=%h pc=%h pc4=%h v=%b addr=%h want inst=%h pc=%h pc4=%h v=%b addr=%h",
                         $time, bus.instD, bus.pcD, bus.pcplus4D,
                         bus.validD, bus.imem_addr, e.inst, e.pc,
                         e.pc4, e.v, e.addr);
            end
`ifdef FETCH_PERF_CNT_EN
            n_cmp++;
            if (perf_stall_cnt !== e.sc ||
                perf_redirect_cnt !== e.rc) begin
                n_err++;
                $display("FAIL perf t=%0t got stall=%0d redir=%0d want stall=%0d redir=%0d",
                         $time, perf_stall_cnt, perf_redirect_cnt,
                         e.sc, e.rc);
            end
`endif
        end
    end

    initial begin
        logic ps, st, fl, r;
        logic [31:0] tg;
        rst = 1'b1;
        bus.pcsrcE = 0; bus.pctargetE = 0;
        bus.stallD = 0; bus.flushD = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(6);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);
        idle(7);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 32'h40, 0, 0);
        idle(3);
        cyc(0, 1, 32'h80, 1, 0);
        idle(3);
        cyc(0, 0, 0, 0, 1);
        idle(3);
        cyc(0, 1, 32'h43, 0, 0);
        idle(3);
        cyc(0, 1, 32'hFFFF_FFF8, 0, 0);
        idle(6);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            ps = ($urandom_range(0, 11) == 0);
            st = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 7) == 0);
            tg = $urandom();
            cyc(r, ps, tg, st, fl);
        end
        idle(4);
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
